// File: rtl/counter_sweep_ctrl.sv
// Command stage for an N-bit up/down counter with parallel load: sweeps the
// counter ping-pong between latched low/high limits a programmed number of times.
module counter_sweep_ctrl #(
  parameter int N    = 3,
  parameter int SW_W = 4
) (
  input  logic            clk,
  input  logic            reset_in,
  input  logic            start_in,
  input  logic            stop_in,
  input  logic [N-1:0]    lo_in,
  input  logic [N-1:0]    hi_in,
  input  logic [SW_W-1:0] sweeps_in,
  input  logic [N-1:0]    count_in,
  output logic            load_out,
  output logic [N-1:0]    d_out,
  output logic            up_down_out,
  output logic            busy_out,
  output logic            done_out,
  output logic            err_out
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_UP   = 3'd2;
  localparam logic [2:0] S_DOWN = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]      r_state;
  logic [N-1:0]    r_lo;
  logic [N-1:0]    r_hi;
  logic [SW_W-1:0] r_rem;
  logic            r_load;
  logic [N-1:0]    r_d;
  logic            r_up;
  logic            r_busy;
  logic            r_done;
  logic            r_err;

  logic [N-1:0] w_hi_m1;
  logic [N-1:0] w_lo_p1;
  logic         w_start_ok;
  logic         w_out_of_range;

  // lo_r < hi_r always holds while sweeping, so neither expression can wrap.
  assign w_hi_m1        = r_hi - N'(1);
  assign w_lo_p1        = r_lo + N'(1);
  assign w_start_ok     = (lo_in < hi_in) && (sweeps_in != '0);
  assign w_out_of_range = (count_in < r_lo) || (count_in > r_hi);

  always_ff @(posedge clk) begin
    if (reset_in) begin
      r_state <= S_IDLE;
      r_lo    <= '0;
      r_hi    <= '0;
      r_rem   <= '0;
      r_load  <= 1'b1;
      r_d     <= '0;
      r_up    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_load <= 1'b1;
          r_d    <= r_lo;
          r_up   <= 1'b1;
          r_busy <= 1'b0;
          if (start_in) begin
            if (w_start_ok) begin
              r_lo    <= lo_in;
              r_hi    <= hi_in;
              r_rem   <= sweeps_in;
              r_d     <= lo_in;
              r_busy  <= 1'b1;
              r_state <= S_LOAD;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (stop_in) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= S_UP;
            r_load  <= 1'b0;
            r_up    <= 1'b1;
          end
        end
        S_UP, S_DOWN: begin
          // Abort, then tracking fault, then the normal reversal/completion.
          if (stop_in || w_out_of_range) begin
            r_state <= S_IDLE;
            r_load  <= 1'b1;
            r_d     <= r_lo;
            r_up    <= 1'b1;
            r_busy  <= 1'b0;
            r_err   <= !stop_in;
          end else if (r_state == S_UP) begin
            if (count_in == w_hi_m1) begin
              r_state <= S_DOWN;
              r_up    <= 1'b0;
            end
          end else if (count_in == w_lo_p1) begin
            if (r_rem > SW_W'(1)) begin
              r_rem   <= r_rem - SW_W'(1);
              r_state <= S_UP;
              r_up    <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_load  <= 1'b1;
              r_d     <= r_lo;
              r_up    <= 1'b1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_load  <= 1'b1;
          r_d     <= r_lo;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_load  <= 1'b1;
          r_d     <= r_lo;
          r_up    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign load_out    = r_load;
  assign d_out       = r_d;
  assign up_down_out = r_up;
  assign busy_out    = r_busy;
  assign done_out    = r_done;
  assign err_out     = r_err;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl driving a behavioural 3-bit up/down counter;
// expected count traces are built from the ping-pong sweep rules.
module tb_counter_sweep_ctrl;

  logic       clk = 1'b0;
  logic       reset_in;
  logic       start_in;
  logic       stop_in;
  logic [2:0] lo_in;
  logic [2:0] hi_in;
  logic [3:0] sweeps_in;
  logic [2:0] count_in;
  logic       load_out;
  logic [2:0] d_out;
  logic       up_down_out;
  logic       busy_out;
  logic       done_out;
  logic       err_out;

  logic [2:0] cnt;
  logic       force_en;
  logic [2:0] force_val;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [2:0] lo;
    logic [2:0] hi;
    logic [3:0] sw;
    bit         err;
    int         cycles;
  } vec_t;

  vec_t tbl[6];

  always #5 clk = ~clk;

  counter_sweep_ctrl #(.N(3), .SW_W(4)) dut (
    .clk        (clk),
    .reset_in   (reset_in),
    .start_in   (start_in),
    .stop_in    (stop_in),
    .lo_in      (lo_in),
    .hi_in      (hi_in),
    .sweeps_in  (sweeps_in),
    .count_in   (count_in),
    .load_out   (load_out),
    .d_out      (d_out),
    .up_down_out(up_down_out),
    .busy_out   (busy_out),
    .done_out   (done_out),
    .err_out    (err_out)
  );

  // The driven counter
  always @(posedge clk) begin
    if (reset_in)         cnt <= 3'd0;
    else if (load_out)    cnt <= d_out;
    else if (up_down_out) cnt <= cnt + 3'd1;
    else                  cnt <= cnt - 3'd1;
  end

  assign count_in = force_en ? force_val : cnt;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Start a sweep and follow it cycle by cycle against the expected trace.
  task automatic run_start(input logic [2:0] lo, input logic [2:0] hi,
                           input logic [3:0] sw, input bit exp_err,
                           input int exp_cycles, input string tag);
    int seq[$];
    int len;
    int prior;
    prior     = cnt;
    start_in  = 1'b1;
    lo_in     = lo;
    hi_in     = hi;
    sweeps_in = sw;
    tick();
    start_in  = 1'b0;
    lo_in     = 3'($urandom);
    hi_in     = 3'($urandom);
    sweeps_in = 4'($urandom);
    if (exp_err) begin
      check({tag, " err"}, {err_out, busy_out}, 2'b10);
      tick();
      check({tag, " err gone"}, {err_out, busy_out}, 2'b00);
      check({tag, " held"}, cnt, prior);
      check({tag, " d held"}, d_out, prior);
      return;
    end
    check({tag, " load"}, {busy_out, load_out, d_out}, {2'b11, lo});
    seq.push_back(int'(lo));
    for (int s = 0; s < int'(sw); s++) begin
      for (int v = int'(lo) + 1; v <= int'(hi); v++) seq.push_back(v);
      for (int v = int'(hi) - 1; v >= int'(lo); v--) seq.push_back(v);
    end
    len = seq.size();
    for (int i = 0; i < len; i++) begin
      tick();
      check({tag, " count"}, cnt, seq[i]);
      if (i < len - 1) begin
        check({tag, " busy"}, {busy_out, done_out}, 2'b10);
      end else begin
        check({tag, " done"}, {busy_out, done_out}, 2'b01);
        check({tag, " latency"}, i + 2, exp_cycles);
      end
    end
    tick();
    check({tag, " idle"}, {busy_out, done_out, load_out}, 3'b001);
    check({tag, " rest"}, cnt, lo);
  endtask

  initial begin
    tbl[0] = '{3'd2, 3'd5, 4'd1, 1'b0, 8};
    tbl[1] = '{3'd0, 3'd7, 4'd2, 1'b0, 30};
    tbl[2] = '{3'd3, 3'd4, 4'd3, 1'b0, 8};
    tbl[3] = '{3'd5, 3'd5, 4'd1, 1'b1, 0};
    tbl[4] = '{3'd6, 3'd2, 4'd2, 1'b1, 0};
    tbl[5] = '{3'd1, 3'd3, 4'd0, 1'b1, 0};

    reset_in  = 1'b1;
    start_in  = 1'b0;
    stop_in   = 1'b0;
    lo_in     = 3'd0;
    hi_in     = 3'd0;
    sweeps_in = 4'd0;
    force_en  = 1'b0;
    force_val = 3'd0;

    tick();
    check("reset outputs", {load_out, d_out, up_down_out, busy_out, done_out, err_out},
          {1'b1, 3'd0, 1'b1, 3'b000});
    check("reset count", cnt, 0);
    tick();
    reset_in = 1'b0;
    tick();

    foreach (tbl[k]) run_start(tbl[k].lo, tbl[k].hi, tbl[k].sw, tbl[k].err,
                               tbl[k].cycles, $sformatf("tbl%0d", k));

    // Abort in UP at count 4, with an ignored start while busy.
    start_in = 1'b1; lo_in = 3'd1; hi_in = 3'd6; sweeps_in = 4'd1;
    tick();
    start_in = 1'b0;
    tick();
    check("stop first", cnt, 1);
    start_in = 1'b1; lo_in = 3'd0; hi_in = 3'd7; sweeps_in = 4'd5;
    tick();
    start_in = 1'b0;
    check("start ignored", {cnt, busy_out}, {3'd2, 1'b1});
    tick();
    tick();
    check("stop at 4", cnt, 4);
    stop_in = 1'b1;
    tick();
    stop_in = 1'b0;
    check("stop exit", {busy_out, done_out, err_out, load_out, d_out}, {4'b0001, 3'd1});
    tick();
    check("stop return", {cnt, done_out}, {3'd1, 1'b0});
    tick();
    check("stop hold", {cnt, done_out, busy_out}, {3'd1, 2'b00});

    // Tracking fault: count forced above hi.
    start_in = 1'b1; lo_in = 3'd1; hi_in = 3'd6; sweeps_in = 4'd2;
    tick();
    start_in = 1'b0;
    tick();
    tick();
    force_en = 1'b1; force_val = 3'd7;
    tick();
    force_en = 1'b0;
    check("fault exit", {err_out, busy_out, load_out, d_out}, {3'b101, 3'd1});
    tick();
    check("fault pulse", {err_out, done_out}, 2'b00);
    tick();
    check("fault return", cnt, 1);

    // Reset mid-sweep.
    start_in = 1'b1; lo_in = 3'd2; hi_in = 3'd7; sweeps_in = 4'd3;
    tick();
    start_in = 1'b0;
    tick();
    tick();
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
    check("midreset", {busy_out, load_out, d_out, up_down_out}, {2'b01, 3'd0, 1'b1});
    tick();
    check("midreset count", cnt, 0);

    for (int r = 0; r < 40; r++) begin
      logic [2:0] lo;
      logic [2:0] hi;
      logic [3:0] sw;
      bit         bad;
      lo  = 3'($urandom_range(0, 7));
      hi  = 3'($urandom_range(0, 7));
      sw  = 4'($urandom_range(0, 3));
      bad = !((lo < hi) && (sw != 4'd0));
      run_start(lo, hi, sw, bad, 2 + 2 * int'(sw) * (int'(hi) - int'(lo)),
                $sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
